// File: rtl/sample_collector_mc.sv
// rtl/sample_collector_mc.sv - round-robin multi-channel sample collector with FWFT FIFO
module sample_collector_mc #(
    parameter int  POSITION  = 242,
    parameter int  MAX_UNITS = 16,
    parameter int  SAMPLE_W  = 12,
    parameter int  FIFO_AW   = 10,
    parameter int  TIMEOUT   = 15,
    localparam int IDX_W     = (MAX_UNITS > 1) ? $clog2(MAX_UNITS) : 1,
    localparam int FIFO_W    = IDX_W + SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         addr,
    input  logic [31:0]         cmd_data_in,
    input  logic                cs,
    input  logic                wr,
    input  logic                rd,
    output logic [31:0]         cmd_data_out,
    output logic                sample_req,
    output logic [7:0]          channel_select,
    input  logic [31:0]         sample_data,
    input  logic                sample_valid,
    input  logic                fifo_rd_en,
    output logic [FIFO_W-1:0]   fifo_dout,
    output logic                fifo_empty,
    output logic [FIFO_AW:0]    fifo_count,
    output logic                overflow
);
    localparam int NUM_W = IDX_W + 1;
    localparam int WC_W  = $clog2(TIMEOUT + 1);
    localparam logic [7:0]       UNIT_ADDR = 8'(POSITION);
    localparam logic [NUM_W-1:0] MAX_N     = NUM_W'(MAX_UNITS);
    localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(TIMEOUT - 1);
    localparam logic [FIFO_AW:0] DEPTH     = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_STORE, S_NEXT} state_t;
    state_t state, state_nx;

    logic                sel, wr_sel, wr_sel_q, wr_pulse, rd_sel;
    logic                cmd_start, cmd_stop, cmd_reset, cmd_clr_ovf;
    logic [7:0]          list_pos [MAX_UNITS];
    logic [NUM_W-1:0]    num_units;
    logic                change_only;
    logic [7:0]          dec;
    logic [31:0]         rd_mux;
    logic                running;

    logic [IDX_W-1:0]    idx;
    logic [7:0]          dec_cnt;
    logic [WC_W-1:0]     wait_cnt;
    logic [SAMPLE_W-1:0] sample_q;
    logic                stop_pending;
    logic [MAX_UNITS-1:0] seen;
    logic [SAMPLE_W-1:0] last_s [MAX_UNITS];
    logic                idx_wrap;

    logic [FIFO_W-1:0]   mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]  wptr, rptr;
    logic                fifo_full, store_push, push_ok, pop, drop;

    logic                unused_sample_bits;
    assign unused_sample_bits = ^sample_data[31:SAMPLE_W];

    // Writes act only on the rising edge of the qualified strobe.
    assign sel         = cs && (addr[15:8] == UNIT_ADDR);
    assign wr_sel      = sel && wr;
    assign wr_pulse    = wr_sel && !wr_sel_q;
    assign rd_sel      = sel && rd;
    assign cmd_start   = wr_pulse && (addr[7:0] == 8'd5) && (cmd_data_in == 32'd1);
    assign cmd_stop    = wr_pulse && (addr[7:0] == 8'd5) && (cmd_data_in == 32'd2);
    assign cmd_reset   = wr_pulse && (addr[7:0] == 8'd5) && (cmd_data_in == 32'd5);
    assign cmd_clr_ovf = wr_pulse && (addr[7:0] == 8'd5) && (cmd_data_in == 32'd6);
    assign running     = (state != S_IDLE);

    always_comb begin
        rd_mux = '0;
        case (addr[7:0])
            8'd6: rd_mux[NUM_W-1:0] = num_units;
            8'd7: begin
                rd_mux[0]    = change_only;
                rd_mux[15:8] = dec;
            end
            8'd8: rd_mux[FIFO_AW+3:0] = {overflow, running, fifo_empty, fifo_count};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel_q     <= 1'b0;
            num_units    <= '0;
            change_only  <= 1'b0;
            dec          <= '0;
            cmd_data_out <= '0;
            for (int i = 0; i < MAX_UNITS; i++) list_pos[i] <= '0;
        end else begin
            wr_sel_q     <= wr_sel;
            cmd_data_out <= rd_sel ? rd_mux : '0;
            if (cmd_reset) begin
                num_units   <= '0;
                change_only <= 1'b0;
                dec         <= '0;
                for (int i = 0; i < MAX_UNITS; i++) list_pos[i] <= '0;
            end else if (wr_pulse) begin
                if (addr[7:0] == 8'd4 && num_units < MAX_N) begin
                    list_pos[num_units[IDX_W-1:0]] <= cmd_data_in[7:0];
                    num_units <= num_units + 1'b1;
                end
                if (addr[7:0] == 8'd7) begin
                    change_only <= cmd_data_in[0];
                    dec         <= cmd_data_in[15:8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           state <= S_IDLE;
        else if (cmd_reset) state <= S_IDLE;
        else                state <= state_nx;
    end

    assign idx_wrap = (NUM_W'(idx) + 1'b1) >= num_units;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_start && num_units != '0) state_nx = S_REQ;
            S_REQ:   state_nx = sample_valid ? S_STORE : S_WAIT;
            S_WAIT:  if (sample_valid) state_nx = S_STORE;
                     else if (wait_cnt == WC_LAST) state_nx = S_NEXT;
            S_STORE: state_nx = S_NEXT;
            S_NEXT:  state_nx = (stop_pending || cmd_stop) ? S_IDLE : S_REQ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        sample_req     = (state == S_REQ);
        channel_select = (state == S_IDLE) ? 8'hFF : list_pos[idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx          <= '0;
            dec_cnt      <= '0;
            wait_cnt     <= '0;
            sample_q     <= '0;
            stop_pending <= 1'b0;
            seen         <= '0;
            for (int i = 0; i < MAX_UNITS; i++) last_s[i] <= '0;
        end else if (cmd_reset) begin
            idx          <= '0;
            dec_cnt      <= '0;
            wait_cnt     <= '0;
            sample_q     <= '0;
            stop_pending <= 1'b0;
            seen         <= '0;
            for (int i = 0; i < MAX_UNITS; i++) last_s[i] <= '0;
        end else begin
            if (cmd_stop && running) stop_pending <= 1'b1;
            case (state)
                S_IDLE: begin
                    stop_pending <= 1'b0;
                    if (state_nx == S_REQ) begin
                        idx     <= '0;
                        dec_cnt <= '0;
                        seen    <= '0;
                    end
                end
                S_REQ: begin
                    wait_cnt <= '0;
                    if (sample_valid) sample_q <= sample_data[SAMPLE_W-1:0];
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (sample_valid) sample_q <= sample_data[SAMPLE_W-1:0];
                end
                S_STORE: begin
                    last_s[idx] <= sample_q;
                    seen[idx]   <= 1'b1;
                end
                S_NEXT: begin
                    if (idx_wrap) begin
                        idx     <= '0;
                        dec_cnt <= (dec_cnt >= dec) ? 8'd0 : dec_cnt + 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                    if (state_nx == S_IDLE) stop_pending <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Decimated rounds and unchanged repeats still refresh last/seen but never push.
    assign store_push = (state == S_STORE) && (dec_cnt == 8'd0) &&
                        (!change_only || !seen[idx] || (sample_q != last_s[idx]));
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DEPTH);
    assign pop        = fifo_rd_en && !fifo_empty;
    assign push_ok    = store_push && (!fifo_full || pop);
    assign drop       = store_push && fifo_full && !pop;
    assign fifo_dout  = fifo_empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= {idx, sample_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else if (cmd_reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
            if (drop)             overflow <= 1'b1;
            else if (cmd_clr_ovf) overflow <= 1'b0;
        end
    end
endmodule
